// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared constants for the pipeline hazard blocks.
// Holds the hazard FSM state encodings, the register-zero constant and the
// forwarding select codes, so the hazard controller and the forwarding unit
// agree on one set of definitions.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'b00000;

  // Forwarding mux select codes
  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_MEM_WB = 2'b10;

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Load-use hazard detector (purely combinational).
// Flags the case where the load currently in EX writes a register that the
// instruction in ID reads; forwarding cannot cover this, so a bubble is needed.
// Writes to register zero never create a dependency.
// Ports:
//   mem_read  in  1  instruction in EX is a load
//   ex_rt     in  5  load destination register
//   id_rs     in  5  rs of instruction in ID
//   id_rt     in  5  rt of instruction in ID
//   load_use  out 1  hazard detected
module pipeline_hazard_controller_load_use_detector
  import pipeline_hazard_controller_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use
);

  assign load_use = mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Drives PC, IF/ID and ID/EX enables for load-use bubbles, taken-branch
// flushes and data-memory wait freezes. Multi-cycle stalls/flushes are held
// by a small FSM with a down-counter; a memory wait remembers the state it
// interrupted and resumes it with the counter untouched.
// Optional build macro HAZARD_STATS_EN adds saturating 32-bit event counters.
// Ports:
//   clk, rst_n (async, active-low)
//   ID_EX_mem_read_out, ID_EX_rt_out, IF_ID_rs_out, IF_ID_rt_out : load-use inputs
//   branch_taken, EX_MEM_mem_access_out, dmem_ready               : branch / memory
//   pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipeline_freeze : controls
//   hazard_state : registered FSM state
//   stall_count, flush_count, freeze_count : (HAZARD_STATS_EN only)
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ID_EX_mem_read_out,
  input  logic [4:0]  ID_EX_rt_out,
  input  logic [4:0]  IF_ID_rs_out,
  input  logic [4:0]  IF_ID_rt_out,
  input  logic        branch_taken,
  input  logic        EX_MEM_mem_access_out,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        IF_ID_write,
  output logic        ID_EX_bubble,
  output logic        IF_ID_flush,
  output logic        pipeline_freeze,
  output logic [1:0]  hazard_state
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
  output logic [31:0] freeze_count
`endif
);

  localparam logic [1:0] LS_CNT = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [1:0] FL_CNT = 2'(FLUSH_CYCLES - 1);

  hz_state_e  state_q, state_d;
  hz_state_e  ret_state_q, ret_state_d;
  hz_state_e  eff_state;
  logic [1:0] cnt_q, cnt_d;
  logic       load_use, mem_stall;
  logic       pc_write_c, if_id_write_c, bubble_c, flush_c, freeze_c;

  pipeline_hazard_controller_load_use_detector u_load_use (
    .mem_read (ID_EX_mem_read_out),
    .ex_rt    (ID_EX_rt_out),
    .id_rs    (IF_ID_rs_out),
    .id_rt    (IF_ID_rt_out),
    .load_use (load_use)
  );

  assign mem_stall = EX_MEM_mem_access_out && !dmem_ready;

  always_comb begin
    state_d       = state_q;
    ret_state_d   = ret_state_q;
    cnt_d         = cnt_q;
    pc_write_c    = 1'b1;
    if_id_write_c = 1'b1;
    bubble_c      = 1'b0;
    flush_c       = 1'b0;
    freeze_c      = 1'b0;
    // On the completing cycle of a memory wait, behave as the interrupted state.
    eff_state     = (state_q == MEM_WAIT) ? ret_state_q : state_q;

    if (state_q == MEM_WAIT && !dmem_ready) begin
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
      freeze_c      = 1'b1;
    end else if (mem_stall) begin
      // Counter is held so the interrupted stall/flush resumes where it was.
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
      freeze_c      = 1'b1;
      state_d       = MEM_WAIT;
      ret_state_d   = eff_state;
    end else begin
      case (eff_state)
        LOAD_STALL: begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          bubble_c      = 1'b1;
          state_d       = (cnt_q <= 2'd1) ? RUN : LOAD_STALL;
          cnt_d         = (cnt_q <= 2'd1) ? 2'd0 : cnt_q - 2'd1;
        end
        FLUSH: begin
          flush_c = 1'b1;
          state_d = (cnt_q <= 2'd1) ? RUN : FLUSH;
          cnt_d   = (cnt_q <= 2'd1) ? 2'd0 : cnt_q - 2'd1;
        end
        default: begin
          state_d = RUN;
          // A branch under a load-use hazard is dropped: its operand is stale.
          if (load_use) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            bubble_c      = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = LS_CNT;
            end
          end else if (branch_taken) begin
            flush_c = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              cnt_d   = FL_CNT;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ret_state_q <= RUN;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      cnt_q       <= cnt_d;
    end
  end

  // Reset forces a safe hold: nothing advances, ID/EX and IF/ID carry nops.
  assign pc_write        = rst_n & pc_write_c;
  assign IF_ID_write     = rst_n & if_id_write_c;
  assign ID_EX_bubble    = ~rst_n | bubble_c;
  assign IF_ID_flush     = ~rst_n | flush_c;
  assign pipeline_freeze = rst_n & freeze_c;
  assign hazard_state    = state_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic [31:0] freeze_count_q, freeze_count_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    stall_count_d  = sat_inc(stall_count_q, ID_EX_bubble);
    flush_count_d  = sat_inc(flush_count_q, IF_ID_flush);
    freeze_count_d = sat_inc(freeze_count_q, pipeline_freeze);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q  <= 32'd0;
      flush_count_q  <= 32'd0;
      freeze_count_q <= 32'd0;
    end else begin
      stall_count_q  <= stall_count_d;
      flush_count_q  <= flush_count_d;
      freeze_count_q <= freeze_count_d;
    end
  end

  assign stall_count  = stall_count_q;
  assign flush_count  = flush_count_q;
  assign freeze_count = freeze_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller. Three instances share the
// same inputs: u1 (LOAD_STALL_CYCLES=1, FLUSH_CYCLES=1), u2 (2,2), u3 (3,2).
module tb_pipeline_hazard_controller;

  logic       clk;
  logic       rst_n;
  logic       mr;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       br, ma, rdy;

  logic [3:1] pcw, ifw, bub, fls, frz;
  logic [1:0] hs [1:3];
  logic [31:0] st_c [1:3];
  logic [31:0] fl_c [1:3];
  logic [31:0] fz_c [1:3];

  int n_cmp = 0;
  int n_mis = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_controller #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ID_EX_mem_read_out(mr), .ID_EX_rt_out(ex_rt),
    .IF_ID_rs_out(id_rs), .IF_ID_rt_out(id_rt), .branch_taken(br),
    .EX_MEM_mem_access_out(ma), .dmem_ready(rdy),
    .pc_write(pcw[1]), .IF_ID_write(ifw[1]), .ID_EX_bubble(bub[1]),
    .IF_ID_flush(fls[1]), .pipeline_freeze(frz[1]), .hazard_state(hs[1])
`ifdef HAZARD_STATS_EN
    , .stall_count(st_c[1]), .flush_count(fl_c[1]), .freeze_count(fz_c[1])
`endif
  );

  pipeline_hazard_controller #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .ID_EX_mem_read_out(mr), .ID_EX_rt_out(ex_rt),
    .IF_ID_rs_out(id_rs), .IF_ID_rt_out(id_rt), .branch_taken(br),
    .EX_MEM_mem_access_out(ma), .dmem_ready(rdy),
    .pc_write(pcw[2]), .IF_ID_write(ifw[2]), .ID_EX_bubble(bub[2]),
    .IF_ID_flush(fls[2]), .pipeline_freeze(frz[2]), .hazard_state(hs[2])
`ifdef HAZARD_STATS_EN
    , .stall_count(st_c[2]), .flush_count(fl_c[2]), .freeze_count(fz_c[2])
`endif
  );

  pipeline_hazard_controller #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2)) u3 (
    .clk(clk), .rst_n(rst_n), .ID_EX_mem_read_out(mr), .ID_EX_rt_out(ex_rt),
    .IF_ID_rs_out(id_rs), .IF_ID_rt_out(id_rt), .branch_taken(br),
    .EX_MEM_mem_access_out(ma), .dmem_ready(rdy),
    .pc_write(pcw[3]), .IF_ID_write(ifw[3]), .ID_EX_bubble(bub[3]),
    .IF_ID_flush(fls[3]), .pipeline_freeze(frz[3]), .hazard_state(hs[3])
`ifdef HAZARD_STATS_EN
    , .stall_count(st_c[3]), .flush_count(fl_c[3]), .freeze_count(fz_c[3])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  // Advance to just after the next active edge, where inputs are changed.
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  // Sample point: opposite clock edge.
  task automatic look();
    @(negedge clk);
  endtask

  task automatic drive(input logic m, input logic [4:0] xr, input logic [4:0] rs,
                       input logic [4:0] rt, input logic b, input logic a, input logic r);
    mr = m; ex_rt = xr; id_rs = rs; id_rt = rt; br = b; ma = a; rdy = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      go();
      drive(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Reset state
    look();
    chk("rst_pc", pcw[1], 1'b0);
    chk("rst_ifw", ifw[1], 1'b0);
    chk("rst_bub", bub[1], 1'b1);
    chk("rst_fls", fls[1], 1'b1);
    chk("rst_frz", frz[1], 1'b0);
    chk("rst_hs", hs[1], 2'd0);
    go();
    rst_n = 1'b1;
    look();
    chk("idle_pc", pcw[1], 1'b1);
    chk("idle_ifw", ifw[1], 1'b1);
    chk("idle_bub", bub[1], 1'b0);
    chk("idle_fls", fls[1], 1'b0);

    // Load-use via rs, all three stall lengths
    go(); drive(1, 5, 5, 0, 0, 0, 0);
    look();
    chk("lu1_bub_c1", bub[1], 1'b1);
    chk("lu1_pc_c1", pcw[1], 1'b0);
    chk("lu2_bub_c1", bub[2], 1'b1);
    chk("lu_hs_c1", hs[2], 2'd0);
    go(); drive(0, 0, 0, 0, 0, 0, 0);
    look();
    chk("lu1_bub_c2", bub[1], 1'b0);
    chk("lu1_pc_c2", pcw[1], 1'b1);
    chk("lu2_bub_c2", bub[2], 1'b1);
    chk("lu2_pc_c2", pcw[2], 1'b0);
    chk("lu2_hs_c2", hs[2], 2'd1);
    chk("lu3_hs_c2", hs[3], 2'd1);
    go();
    look();
    chk("lu2_bub_c3", bub[2], 1'b0);
    chk("lu2_hs_c3", hs[2], 2'd0);
    chk("lu3_bub_c3", bub[3], 1'b1);
    chk("lu3_hs_c3", hs[3], 2'd1);
    go();
    look();
    chk("lu3_bub_c4", bub[3], 1'b0);
    chk("lu3_hs_c4", hs[3], 2'd0);

    // Register-zero guard
    go(); drive(1, 0, 0, 0, 0, 0, 0);
    look();
    chk("r0_bub", bub[1], 1'b0);
    chk("r0_pc", pcw[1], 1'b1);

    // Load-use via rt field
    go(); drive(1, 7, 3, 7, 0, 0, 0);
    look();
    chk("lurt_bub", bub[1], 1'b1);
    go(); drive(1, 7, 3, 6, 0, 0, 0);
    look();
    chk("nomatch_bub", bub[1], 1'b0);
    idle(3);

    // Taken branch
    go(); drive(0, 0, 0, 0, 1, 0, 0);
    look();
    chk("br1_fls_c1", fls[1], 1'b1);
    chk("br2_fls_c1", fls[2], 1'b1);
    chk("br2_pc_c1", pcw[2], 1'b1);
    chk("br2_bub_c1", bub[2], 1'b0);
    go(); drive(0, 0, 0, 0, 0, 0, 0);
    look();
    chk("br1_fls_c2", fls[1], 1'b0);
    chk("br2_fls_c2", fls[2], 1'b1);
    chk("br2_pc_c2", pcw[2], 1'b1);
    chk("br2_hs_c2", hs[2], 2'd2);
    go();
    look();
    chk("br2_fls_c3", fls[2], 1'b0);
    chk("br2_hs_c3", hs[2], 2'd0);

    // Branch masked by load-use
    go(); drive(1, 5, 5, 0, 1, 0, 0);
    look();
    chk("brlu_bub", bub[1], 1'b1);
    chk("brlu_fls", fls[1], 1'b0);
    chk("brlu_pc", pcw[1], 1'b0);
    idle(3);

    // Asynchronous reset in the middle of a load stall
    go(); drive(1, 5, 5, 0, 0, 0, 0);
    go(); drive(0, 0, 0, 0, 0, 0, 0);
    look();
    chk("mid_hs_pre", hs[3], 2'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", pcw[3], 1'b0);
    chk("mid_rst_fls", fls[3], 1'b1);
    chk("mid_rst_hs", hs[3], 2'd0);
    go();
    rst_n = 1'b1;
    look();
    chk("post_rst_pc", pcw[3], 1'b1);
    chk("post_rst_ifw", ifw[3], 1'b1);

    // Memory wait inside a 3-cycle load stall
    go(); drive(1, 5, 5, 0, 0, 0, 0);
    look();
    chk("mw_c1_bub", bub[3], 1'b1);
    chk("mw_c1_frz", frz[3], 1'b0);
    go(); drive(0, 0, 0, 0, 0, 1, 0);
    look();
    chk("mw_c2_frz", frz[3], 1'b1);
    chk("mw_c2_bub", bub[3], 1'b0);
    chk("mw_c2_pc", pcw[3], 1'b0);
    chk("mw_c2_hs", hs[3], 2'd1);
    for (int i = 3; i <= 5; i++) begin
      go();
      look();
      chk($sformatf("mw_c%0d_frz", i), frz[3], 1'b1);
      chk($sformatf("mw_c%0d_hs", i), hs[3], 2'd3);
    end
    go(); drive(0, 0, 0, 0, 0, 1, 1);
    look();
    chk("mw_c6_frz", frz[3], 1'b0);
    chk("mw_c6_bub", bub[3], 1'b1);
    chk("mw_c6_pc", pcw[3], 1'b0);
    go(); drive(0, 0, 0, 0, 0, 0, 0);
    look();
    chk("mw_c7_bub", bub[3], 1'b1);
    chk("mw_c7_hs", hs[3], 2'd1);
    go();
    look();
    chk("mw_c8_bub", bub[3], 1'b0);
    chk("mw_c8_hs", hs[3], 2'd0);
    chk("mw_c8_pc", pcw[3], 1'b1);
`ifdef HAZARD_STATS_EN
    chk("stat_freeze", fz_c[3], 32'd4);
    chk("stat_stall", st_c[3], 32'd3);
    chk("stat_flush", fl_c[3], 32'd0);
`endif

    // Memory wait from RUN, then back to RUN
    go(); drive(0, 0, 0, 0, 0, 1, 0);
    look();
    chk("mr_frz", frz[1], 1'b1);
    chk("mr_ifw", ifw[1], 1'b0);
    go(); drive(0, 0, 0, 0, 0, 1, 1);
    look();
    chk("mr_done_frz", frz[1], 1'b0);
    chk("mr_done_pc", pcw[1], 1'b1);
    chk("mr_done_hs", hs[1], 2'd3);
    go(); drive(0, 0, 0, 0, 0, 0, 0);
    look();
    chk("mr_back_hs", hs[1], 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
